// File: rtl/signed_convert_pkg.sv
// Shared mode encodings and MIN/MAX constant helpers for the signed converter.
package signed_convert_pkg;

   localparam logic [1:0] MODE_PASS  = 2'b00;
   localparam logic [1:0] MODE_NEG   = 2'b01;
   localparam logic [1:0] MODE_ABS   = 2'b10;
   localparam logic [1:0] MODE_SM2TC = 2'b11;

   // Most negative n-bit two's-complement value, right-aligned in 64 bits (n <= 64).
   function automatic logic [63:0] min_val(input int n);
      return 64'd1 << (n - 1);
   endfunction

   // Most positive n-bit two's-complement value, right-aligned in 64 bits (n <= 64).
   function automatic logic [63:0] max_val(input int n);
      return min_val(n) - 64'd1;
   endfunction

endpackage

// File: rtl/signed_convert_pipe_if.sv
// Valid/ready stream bundle for the converter: input group + mode, output group + flags.
interface signed_convert_pipe_if #(
   parameter int N  = 16,
   parameter int CH = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [CH*N-1:0]   in_data;
   logic [1:0]        mode;
   logic              out_valid;
   logic              out_ready;
   logic [CH*N-1:0]   out_data;
   logic [CH-1:0]     out_ovf;

   // Producer/consumer side (drives input stream, accepts output stream).
   modport master (
      output in_valid, in_data, mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   // Converter side.
   modport slave (
      input  in_valid, in_data, mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/signed_convert_lane.sv
// One channel of the converter: pass / negate / abs / sign-magnitude to two's complement.
module signed_convert_lane
   import signed_convert_pkg::*;
#(
   parameter int N   = 16,
   parameter bit SAT = 1'b1
) (
   input  logic [N-1:0] x,
   input  logic [1:0]   mode,
   output logic [N-1:0] y,
   output logic         ovf
);
   localparam logic [63:0]  MIN_W = min_val(N);
   localparam logic [63:0]  MAX_W = max_val(N);
   localparam logic [N-1:0] MIN   = MIN_W[N-1:0];
   localparam logic [N-1:0] MAX   = MAX_W[N-1:0];
   localparam logic [N-1:0] ONE   = N'(1);
   // MIN has no positive counterpart; negating it either clamps or wraps back to MIN.
   localparam logic [N-1:0] MIN_NEG = SAT ? MAX : MIN;

   logic [N-1:0] neg_x;
   logic [N-1:0] mag;
   logic [N-1:0] neg_mag;

   // Per-lane result and overflow flag selected by the captured mode.
   always_comb begin
      neg_x   = ~x + ONE;
      mag     = {1'b0, x[N-2:0]};
      neg_mag = ~mag + ONE;
      y       = x;
      ovf     = 1'b0;
      case (mode)
         MODE_NEG: begin
            if (x == MIN) begin
               ovf = 1'b1;
               y   = MIN_NEG;
            end else begin
               y = neg_x;
            end
         end
         MODE_ABS: begin
            if (x == MIN) begin
               ovf = 1'b1;
               y   = MIN_NEG;
            end else if (x[N-1]) begin
               y = neg_x;
            end
         end
         // Negative zero has zero magnitude, so it falls out as 0 with no special case.
         MODE_SM2TC: y = x[N-1] ? neg_mag : mag;
         default:    y = x;
      endcase
   end

endmodule

// File: rtl/signed_convert_pipe.sv
// Two-stage elastic multi-channel signed converter with saturating overflow counter.
module signed_convert_pipe
   import signed_convert_pkg::*;
#(
   parameter int N     = 16,
   parameter int CH    = 4,
   parameter bit SAT   = 1'b1,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   signed_convert_pipe_if.slave bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     ovf_count
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                      s1_valid_q, s1_valid_d;
   logic [CH-1:0][N-1:0]      s1_data_q,  s1_data_d;
   logic [1:0]                s1_mode_q,  s1_mode_d;
   logic                      s2_valid_q, s2_valid_d;
   logic [CH-1:0][N-1:0]      s2_data_q,  s2_data_d;
   logic [CH-1:0]             s2_ovf_q,   s2_ovf_d;
   logic [CNT_W-1:0]          cnt_q,      cnt_d;

   logic [CH-1:0][N-1:0]      lane_y;
   logic [CH-1:0]             lane_ovf;
   logic                      s2_free, in_hs, s1_adv, out_hs;

   // Ready depends only on pipeline state and out_ready, never on in_valid.
   assign s2_free = !s2_valid_q || bus.out_ready;
   assign s1_adv  = s1_valid_q && s2_free;
   assign in_hs   = bus.in_valid && bus.in_ready;
   assign out_hs  = s2_valid_q && bus.out_ready;

   assign bus.in_ready  = !s1_valid_q || s2_free;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_ovf   = s2_ovf_q;
   assign ovf_count     = cnt_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      signed_convert_lane #(.N(N), .SAT(SAT)) u_lane (
         .x    (s1_data_q[k]),
         .mode (s1_mode_q),
         .y    (lane_y[k]),
         .ovf  (lane_ovf[k])
      );
   end

   // Next-state for both stages and the overflow event counter.
   always_comb begin
      s1_valid_d = in_hs || (s1_valid_q && !s1_adv);
      s1_data_d  = in_hs ? bus.in_data : s1_data_q;
      s1_mode_d  = in_hs ? bus.mode    : s1_mode_q;
      s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
      s2_data_d  = s1_adv ? lane_y   : s2_data_q;
      s2_ovf_d   = s1_adv ? lane_ovf : s2_ovf_q;
      cnt_d      = cnt_q;
      // Clear wins over a coincident increment; increments stick at all-ones.
      if (cnt_clr)
         cnt_d = '0;
      else if (out_hs && (|s2_ovf_q) && (cnt_q != '1))
         cnt_d = cnt_q + CNT_ONE;
   end

   // Pipeline and counter registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= MODE_PASS;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_ovf_q   <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_ovf_q   <= s2_ovf_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_signed_convert_pipe.sv
// Scoreboard bench: a saturating instance (16-bit counter) and a wrapping instance
// (4-bit counter) see identical stimulus; each has its own expected queue.
module tb_signed_convert_pipe;
   import signed_convert_pkg::*;

   localparam int N  = 16;
   localparam int CH = 4;
   localparam int W  = N * CH;

   typedef struct {
      logic [W-1:0]  d;
      logic [CH-1:0] ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data  = '0;
   logic [1:0]    in_mode  = MODE_PASS;
   logic          out_ready = 1'b1;
   logic          cnt_clr   = 1'b0;
   logic [15:0]   cnt_a_q;
   logic [3:0]    cnt_b_q;

   exp_t          qa[$];
   exp_t          qb[$];
   exp_t          ea, eb;
   int            n_chk = 0;
   int            n_fail = 0;
   int            mdl_cnt_a = 0;
   int            mdl_cnt_b = 0;
   bit            saw_busy = 1'b0;
   bit            stall_q  = 1'b0;
   bit            rnd_done = 1'b0;
   logic [W+CH-1:0] hold_q;

   always #5 clk = ~clk;

   signed_convert_pipe_if #(.N(N), .CH(CH)) bus_a ();
   signed_convert_pipe_if #(.N(N), .CH(CH)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_data   = in_data;
   assign bus_a.mode      = in_mode;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_data   = in_data;
   assign bus_b.mode      = in_mode;
   assign bus_b.out_ready = out_ready;

   signed_convert_pipe #(.N(N), .CH(CH), .SAT(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a), .cnt_clr(cnt_clr), .ovf_count(cnt_a_q));
   signed_convert_pipe #(.N(N), .CH(CH), .SAT(1'b0), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b), .cnt_clr(cnt_clr), .ovf_count(cnt_b_q));

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference lane in integer arithmetic: signed value, exact result, then range check.
   function automatic logic [N-1:0] ref_lane(input logic [1:0] m, input logic [N-1:0] x,
                                             input bit sat, output bit ov);
      longint v, r, mx, mg;
      mx = (longint'(1) << (N - 1)) - 1;
      v  = x[N-1] ? longint'(x) - (longint'(1) << N) : longint'(x);
      mg = longint'(x) & mx;
      case (m)
         2'b00:   r = v;
         2'b01:   r = -v;
         2'b10:   r = (v < 0) ? -v : v;
         default: r = x[N-1] ? -mg : mg;
      endcase
      ov = (r > mx);
      if (ov && sat) r = mx;
      return r[N-1:0];
   endfunction

   function automatic exp_t ref_grp(input logic [1:0] m, input logic [W-1:0] d, input bit sat);
      exp_t e;
      bit   ov;
      for (int k = 0; k < CH; k++) begin
         e.d[k*N +: N] = ref_lane(m, d[k*N +: N], sat, ov);
         e.ovf[k]      = ov;
      end
      return e;
   endfunction

   function automatic logic [N-1:0] rnd_word();
      case ($urandom_range(0, 7))
         0: return 16'h8000;
         1: return 16'h0000;
         2: return 16'hFFFF;
         3: return 16'h7FFF;
         default: return N'($urandom);
      endcase
   endfunction

   function automatic logic [W-1:0] rnd_grp();
      logic [W-1:0] g;
      for (int k = 0; k < CH; k++) g[k*N +: N] = rnd_word();
      return g;
   endfunction

   // Present one group and hold it until accepted; expectation queued at acceptance.
   task automatic send(input logic [1:0] m, input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus_a.in_ready) begin
            qa.push_back(ref_grp(m, d, 1'b1));
            qb.push_back(ref_grp(m, d, 1'b0));
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      chk("send_timeout", 1, 0);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int t = 0; t < 500; t++) begin
         if (qa.size() == 0 && qb.size() == 0) return;
         @(posedge clk); #1;
      end
      chk("drain_timeout", qa.size(), 0);
   endtask

   // Output monitor: scoreboard pops, hold-while-stalled check, counter model.
   always @(negedge clk) begin
      if (rst) begin
         mdl_cnt_a = 0;
         mdl_cnt_b = 0;
         stall_q   = 1'b0;
      end else begin
         chk("cnt_a", cnt_a_q, mdl_cnt_a);
         chk("cnt_b", cnt_b_q, mdl_cnt_b);
         if (stall_q) chk("hold", {bus_a.out_data, bus_a.out_ovf}, hold_q);
         if (!bus_a.in_ready) saw_busy = 1'b1;
         if (bus_a.out_valid && out_ready) begin
            if (qa.size() == 0) chk("spurious_a", 1, 0);
            else begin
               ea = qa.pop_front();
               chk("data_a", bus_a.out_data, ea.d);
               chk("ovf_a", bus_a.out_ovf, ea.ovf);
               if (!cnt_clr && (|ea.ovf) && mdl_cnt_a < 65535) mdl_cnt_a++;
            end
         end
         if (bus_b.out_valid && out_ready) begin
            if (qb.size() == 0) chk("spurious_b", 1, 0);
            else begin
               eb = qb.pop_front();
               chk("data_b", bus_b.out_data, eb.d);
               chk("ovf_b", bus_b.out_ovf, eb.ovf);
               if (!cnt_clr && (|eb.ovf) && mdl_cnt_b < 15) mdl_cnt_b++;
            end
         end
         if (cnt_clr) begin
            mdl_cnt_a = 0;
            mdl_cnt_b = 0;
         end
         stall_q = bus_a.out_valid && !out_ready;
         hold_q  = {bus_a.out_data, bus_a.out_ovf};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] g;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus_a.out_valid, 0);
      chk("rst_out_data", bus_a.out_data, 0);
      chk("rst_out_ovf", bus_a.out_ovf, 0);
      chk("rst_cnt", cnt_a_q, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bus_a.in_ready, 1);
      @(posedge clk); #1;

      // Negate with MIN lane: 2-cycle latency, saturate vs wrap
      send(MODE_NEG, 64'h0000_8000_FFFF_0001);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1_valid", bus_a.out_valid, 0);
      @(negedge clk);
      chk("lat_c2_valid", bus_a.out_valid, 1);
      chk("neg_sat_data", bus_a.out_data, 64'h0000_7FFF_0001_FFFF);
      chk("neg_sat_ovf", bus_a.out_ovf, 4'b0100);
      chk("neg_wrap_data", bus_b.out_data, 64'h0000_8000_0001_FFFF);
      chk("neg_wrap_ovf", bus_b.out_ovf, 4'b0100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("neg_cnt", cnt_a_q, 1);
      @(posedge clk); #1;

      // Sign-magnitude conversion including negative zero
      send(MODE_SM2TC, 64'hFFFF_8000_0005_8005);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sm2tc_data", bus_a.out_data, 64'h8001_0000_0005_FFFB);
      chk("sm2tc_ovf", bus_a.out_ovf, 4'b0000);
      @(posedge clk); #1;

      // Abs stream of 8 groups with a 4-cycle output stall
      saw_busy = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               g = rnd_grp();
               if (i == 2) g[N +: N] = 16'h8000;
               send(MODE_ABS, g);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_in_ready_low", saw_busy, 1);

      // Mixed modes back-to-back with random backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) send(2'($urandom_range(0, 3)), rnd_grp());
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Counter: clear, then 20 overflowing transfers saturate the 4-bit counter
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_cnt_a", cnt_a_q, 0);
      chk("clr_cnt_b", cnt_b_q, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         g = rnd_grp();
         g[N-1:0] = 16'h8000;
         send(MODE_NEG, g);
      end
      drain();
      @(negedge clk);
      chk("cnt_sat_b", cnt_b_q, 15);
      chk("cnt_20_a", cnt_a_q, 20);
      @(posedge clk); #1;

      // Asynchronous reset with two groups in flight
      out_ready = 1'b0;
      send(MODE_NEG, 64'h8000_8000_8000_8000);
      send(MODE_ABS, 64'h8000_1234_FFFF_0001);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      qa.delete();
      qb.delete();
      chk("arst_out_valid", bus_a.out_valid, 0);
      chk("arst_out_data", bus_a.out_data, 0);
      chk("arst_out_ovf", bus_a.out_ovf, 0);
      chk("arst_cnt_a", cnt_a_q, 0);
      chk("arst_cnt_b", cnt_b_q, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("arst_in_ready", bus_a.in_ready, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("arst_no_stale", bus_a.out_valid, 0);

      // Clear coincident with an overflowing output handshake
      g = rnd_grp();
      g[N-1:0] = 16'h8000;
      send(MODE_NEG, g);
      drain();
      @(negedge clk);
      chk("pre_clr_cnt_a", cnt_a_q, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      g = rnd_grp();
      g[N-1:0] = 16'h8000;
      send(MODE_NEG, g);
      in_valid = 1'b0;
      @(posedge clk); #1;
      cnt_clr   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_prio_a", cnt_a_q, 0);
      chk("clr_prio_b", cnt_b_q, 0);
      chk("clr_prio_drained", qa.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
